// File: rtl/detector_pkg.sv
// Shared encodings for the serial pattern generator and its sequence detector.
// One-hot FSM states plus the default detector pattern.
package detector_pkg;
  localparam int STATE_W = 4;

  localparam logic [STATE_W-1:0] S_IDLE  = 4'b0001;
  localparam logic [STATE_W-1:0] S_SHIFT = 4'b0010;
  localparam logic [STATE_W-1:0] S_GAP   = 4'b0100;
  localparam logic [STATE_W-1:0] S_DONE  = 4'b1000;

  localparam logic [3:0] DET_PATTERN = 4'b1011;
endpackage

// File: rtl/pattern_piso.sv
// MSB-first parallel-in serial-out register with bit counter; load wins over shift.
// Zero latency on msb after load; no backpressure, shifts whenever shift=1.
module pattern_piso #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] din,
  output logic             msb,
  output logic             last_bit
);
  localparam int BC_W = $clog2(PAT_W);

  logic [PAT_W-1:0] sh;
  logic [BC_W-1:0]  bit_cnt;

  assign msb      = sh[PAT_W-1];
  assign last_bit = (bit_cnt == BC_W'(PAT_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sh      <= din;
      bit_cnt <= '0;
    end else if (shift) begin
      sh      <= {sh[PAT_W-2:0], 1'b0};
      bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/serial_pattern_gen.sv
// Repeats a captured pattern MSB-first with optional idle gaps; first bit one cycle after start.
// No backpressure: start is only sampled in idle, abort returns to idle on the next clock.
module serial_pattern_gen
  import detector_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [PAT_W-1:0]   pattern_i,
  input  logic [CNT_W-1:0]   repeat_i,
  input  logic [GAP_W-1:0]   gap_i,
  input  logic               abort_i,
  output logic               signal_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [STATE_W-1:0] current_state_o
);
  logic [STATE_W-1:0] state;
  logic [PAT_W-1:0]   pat_q;
  logic [CNT_W-1:0]   rem_cnt;
  logic [GAP_W-1:0]   gap_q;
  logic [GAP_W-1:0]   gap_cnt;

  logic             piso_load;
  logic             piso_shift;
  logic [PAT_W-1:0] piso_din;
  logic             piso_msb;
  logic             last_bit;

  pattern_piso #(.PAT_W(PAT_W)) u_piso (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .load     (piso_load),
    .shift    (piso_shift),
    .din      (piso_din),
    .msb      (piso_msb),
    .last_bit (last_bit)
  );

  // Reloads use the captured copy so mid-operation input changes have no effect.
  always_comb begin
    piso_load  = 1'b0;
    piso_shift = (state == S_SHIFT);
    piso_din   = pat_q;
    if (state == S_IDLE && start_i && repeat_i != '0) begin
      piso_load = 1'b1;
      piso_din  = pattern_i;
    end else if (state == S_SHIFT && !abort_i && last_bit &&
                 rem_cnt != CNT_W'(1) && gap_q == '0) begin
      piso_load = 1'b1;
    end else if (state == S_GAP && !abort_i && gap_cnt == GAP_W'(1)) begin
      piso_load = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= S_IDLE;
      pat_q   <= '0;
      rem_cnt <= '0;
      gap_q   <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            if (repeat_i != '0) begin
              pat_q   <= pattern_i;
              rem_cnt <= repeat_i;
              gap_q   <= gap_i;
              state   <= S_SHIFT;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          if (abort_i) begin
            state <= S_IDLE;
          end else if (last_bit) begin
            rem_cnt <= rem_cnt - 1'b1;
            if (rem_cnt == CNT_W'(1)) begin
              state <= S_DONE;
            end else if (gap_q != '0) begin
              gap_cnt <= gap_q;
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (abort_i) begin
            state <= S_IDLE;
          end else if (gap_cnt == GAP_W'(1)) begin
            state <= S_SHIFT;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Exact compares so an illegal encoding drives every output low.
  assign valid_o         = (state == S_SHIFT);
  assign signal_o        = valid_o & piso_msb;
  assign busy_o          = (state == S_SHIFT) || (state == S_GAP);
  assign done_o          = (state == S_DONE);
  assign current_state_o = state;
endmodule

// File: tb/tb_serial_pattern_gen.sv
// Scoreboard bench for serial_pattern_gen: stimulus pushes expected bits/done markers,
// a negedge monitor pops and compares whenever valid_o or done_o is presented.
module tb_serial_pattern_gen;
  import detector_pkg::*;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;
  localparam int GAP_W = 3;

  logic               clk;
  logic               rst_n;
  logic               start_i;
  logic [PAT_W-1:0]   pattern_i;
  logic [CNT_W-1:0]   repeat_i;
  logic [GAP_W-1:0]   gap_i;
  logic               abort_i;
  logic               signal_o;
  logic               valid_o;
  logic               busy_o;
  logic               done_o;
  logic [STATE_W-1:0] current_state_o;

  serial_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk_i           (clk),
    .rst_i           (rst_n),
    .start_i         (start_i),
    .pattern_i       (pattern_i),
    .repeat_i        (repeat_i),
    .gap_i           (gap_i),
    .abort_i         (abort_i),
    .signal_o        (signal_o),
    .valid_o         (valid_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .current_state_o (current_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic is_done;
    logic bitv;
  } exp_t;

  exp_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         busy_cnt = 0;
  int         bubble_cnt = 0;
  int         det_cnt = 0;
  int         det_last = 0;
  int         det_space = 0;
  int         cyc_no = 0;
  logic [3:0] window = '0;
  bit         mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: scoreboard pop plus a reference 1011 detector on the valid bit stream.
  always @(negedge clk) begin
    exp_t e;
    cyc_no++;
    if (mon_en) begin
      busy_cnt   += int'(busy_o);
      bubble_cnt += int'(busy_o && !valid_o);
      check("signal_gated", {31'd0, signal_o & ~valid_o}, 32'd0);
      if (valid_o) begin
        window = {window[2:0], signal_o};
        if (window == DET_PATTERN) begin
          det_space = cyc_no - det_last;
          det_last  = cyc_no;
          det_cnt++;
        end
      end
      if (valid_o || done_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {30'd0, valid_o, done_o}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_kind", {31'd0, done_o}, {31'd0, e.is_done});
          if (!e.is_done) check("out_bit", {31'd0, signal_o}, {31'd0, e.bitv});
        end
      end
    end
  end

  task automatic push_bits(input logic [PAT_W-1:0] pat, input int nbits);
    exp_t e;
    for (int i = 0; i < nbits; i++) begin
      e.is_done = 1'b0;
      e.bitv    = pat[PAT_W-1 - (i % PAT_W)];
      exp_q.push_back(e);
    end
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.bitv    = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic clear_stats();
    busy_cnt   = 0;
    bubble_cnt = 0;
    det_cnt    = 0;
    det_space  = 0;
    window     = '0;
  endtask

  // Returns at the negedge of cycle k+1, k being the edge that accepts the start.
  task automatic start_op(input logic [PAT_W-1:0] pat, input int rep, input int gap);
    @(negedge clk);
    pattern_i = pat;
    repeat_i  = CNT_W'(rep);
    gap_i     = GAP_W'(gap);
    start_i   = 1'b1;
    @(negedge clk);
    start_i   = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_cyc);
    int cyc = 1;
    while (!done_o && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check(name, cyc, exp_cyc);
    @(negedge clk);
    check({name, "_idle"}, {28'd0, current_state_o}, {28'd0, S_IDLE});
  endtask

  initial begin
    rst_n     = 1'b0;
    start_i   = 1'b1;
    pattern_i = DET_PATTERN;
    repeat_i  = 4'd1;
    gap_i     = '0;
    abort_i   = 1'b0;

    // Reset held with start asserted
    repeat (3) @(negedge clk);
    check("reset_state", {28'd0, current_state_o}, 32'd1);
    check("reset_outs", {28'd0, signal_o, valid_o, busy_o, done_o}, 32'd0);
    start_i = 1'b0;
    rst_n   = 1'b1;
    mon_en  = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", {28'd0, current_state_o}, {28'd0, S_IDLE});
    check("post_reset_busy", busy_cnt, 0);

    // Single pattern
    clear_stats();
    push_bits(DET_PATTERN, 4);
    push_done();
    start_op(DET_PATTERN, 1, 0);
    check("t2_first_valid", {31'd0, valid_o}, 32'd1);
    wait_done("t2_done_cycle", 5);
    check("t2_busy", busy_cnt, 4);
    check("t2_queue_empty", exp_q.size(), 0);

    // Back-to-back repeats
    clear_stats();
    push_bits(DET_PATTERN, 8);
    push_done();
    start_op(DET_PATTERN, 2, 0);
    wait_done("t3_done_cycle", 9);
    check("t3_busy", busy_cnt, 8);
    check("t3_bubbles", bubble_cnt, 0);
    check("t3_detects", det_cnt, 2);
    check("t3_detect_spacing", det_space, 4);
    check("t3_queue_empty", exp_q.size(), 0);

    // Repeats with gap
    clear_stats();
    push_bits(DET_PATTERN, 12);
    push_done();
    start_op(DET_PATTERN, 3, 2);
    wait_done("t4_done_cycle", 17);
    check("t4_busy", busy_cnt, 16);
    check("t4_gap_cycles", bubble_cnt, 4);
    check("t4_detects", det_cnt, 3);
    check("t4_queue_empty", exp_q.size(), 0);

    // Ignored restart and abort in the 6th busy cycle
    clear_stats();
    push_bits(DET_PATTERN, 6);
    start_op(DET_PATTERN, 5, 0);
    @(negedge clk);
    start_i   = 1'b1;
    pattern_i = 4'b0000;
    repeat_i  = 4'd1;
    @(negedge clk);
    start_i   = 1'b0;
    repeat (3) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("t5_abort_state", {28'd0, current_state_o}, {28'd0, S_IDLE});
    check("t5_abort_valid", {31'd0, valid_o}, 32'd0);
    repeat (4) @(negedge clk);
    check("t5_busy", busy_cnt, 6);
    check("t5_queue_empty", exp_q.size(), 0);

    // Zero repeat count
    clear_stats();
    push_done();
    start_op(DET_PATTERN, 0, 3);
    check("t6_no_valid", {31'd0, valid_o}, 32'd0);
    wait_done("t6_done_cycle", 1);
    check("t6_busy", busy_cnt, 0);
    check("t6_queue_empty", exp_q.size(), 0);

    // Illegal one-hot encoding
    @(negedge clk);
    force dut.state = 4'b0110;
    #1;
    check("illegal_seen", {28'd0, current_state_o}, 32'd6);
    check("illegal_outs", {29'd0, valid_o, busy_o, done_o}, 32'd0);
    #2;
    release dut.state;
    @(negedge clk);
    check("illegal_recover", {28'd0, current_state_o}, {28'd0, S_IDLE});

    // Reset mid-operation
    clear_stats();
    push_bits(DET_PATTERN, 2);
    start_op(DET_PATTERN, 2, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_state", {28'd0, current_state_o}, {28'd0, S_IDLE});
    check("midrst_outs", {28'd0, signal_o, valid_o, busy_o, done_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_queue_empty", exp_q.size(), 0);
    check("midrst_idle", {28'd0, current_state_o}, {28'd0, S_IDLE});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/serial_pattern_gen.md
Name: serial_pattern_gen

Overview:
Serial pattern transmitter: on a start request it shifts a programmable PAT_W-bit pattern out MSB-first, one bit per clock. The pattern is repeated a programmable number of times, with an optional idle gap between repeats. This is the stimulus source for the one-hot serial sequence detector. signal_o connects directly to the detector's signal_i, and the state output mirrors the detector's debug port.

Parameters:
PAT_W, 4, pattern length in bits (min 2)
CNT_W, 4, width of the repeat count
GAP_W, 3, width of the inter-repeat gap length

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
start_i  in  1  start request; sampled only in S_IDLE
pattern_i  in  PAT_W  pattern; bit PAT_W-1 is sent first; captured on accepted start
repeat_i  in  CNT_W  number of pattern repeats; captured on accepted start
gap_i  in  GAP_W  idle cycles between repeats; captured on accepted start
abort_i  in  1  synchronous abort; ignored in S_IDLE
signal_o  out  1  serial data; 0 whenever valid_o=0
valid_o  out  1  high while signal_o carries a pattern bit
busy_o  out  1  high in S_SHIFT and S_GAP
done_o  out  1  one-cycle pulse on normal completion
current_state_o  out  4  current one-hot state, for debug

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=S_IDLE, current_state_o=4'b0001
  - signal_o=0, valid_o=0, busy_o=0, done_o=0
  - shift, repeat and gap registers cleared
- State encoding is one-hot: S_IDLE=0001, S_SHIFT=0010, S_GAP=0100, S_DONE=1000. Any illegal encoding goes to S_IDLE on the next clock.
- S_IDLE:
  - start_i=1 and repeat_i!=0 -> capture pattern_i, repeat_i, gap_i; bit counter=0; go to S_SHIFT.
  - start_i=1 and repeat_i==0 -> go to S_DONE; no bits are sent.
- S_SHIFT:
  - valid_o=1; signal_o = shift register MSB.
  - Each clock, shift left by 1 and increment the bit counter.
  - After bit PAT_W-1 of a repeat, decrement the remaining-repeat count, then:
    - remaining==0 -> S_DONE
    - gap==0 -> reload the captured pattern and stay in S_SHIFT (back-to-back, no bubble)
    - otherwise -> S_GAP, gap counter loaded with gap
- S_GAP:
  - valid_o=0, signal_o=0.
  - Stay for exactly gap cycles, then reload the pattern and go to S_SHIFT.
- S_DONE: done_o=1 for one cycle, then S_IDLE.
  - A new start is accepted only from S_IDLE, so starts are at least 2 cycles apart.
- start_i outside S_IDLE is ignored; it is not queued.
- abort_i=1 in S_SHIFT, S_GAP or S_DONE: next state is S_IDLE and signal_o/valid_o=0 from the next cycle. No done_o pulse follows.
- Timing:
  - Start accepted at edge k -> first bit visible after edge k, i.e. valid in cycle k+1.
  - Outputs are decoded from registered state and shift register only; there is no combinational path from any input to any output.
  - Total busy cycles = R*PAT_W + (R-1)*G, where R=repeat_i and G=gap_i.
  - done_o rises the cycle after the last bit.
- The captured pattern is held stable for the whole operation; changes on pattern_i, repeat_i and gap_i mid-operation have no effect.
- Reset asserted mid-operation: immediate return to reset values; no done_o pulse.

Decomposition:
- Shared package (detector_pkg): one-hot state localparams S_IDLE/S_SHIFT/S_GAP/S_DONE, STATE_W=4, and the default test pattern DET_PATTERN=4'b1011.
- One natural sub-module, pattern_piso: parallel-load, MSB-first shift register with load and shift enables, plus the bit counter and a last_bit flag. The FSM and the repeat/gap counters stay in the top module.

Test Plan:
1. Reset: hold rst_i=0 for 3 cycles with start_i=1 -> current_state_o=0001; signal_o, valid_o, busy_o and done_o all 0; nothing sent after release until a new start.
2. Single pattern: pattern_i=4'b1011, repeat_i=1, gap_i=0, start pulse at edge k -> signal_o=1,0,1,1 in cycles k+1..k+4 with valid_o=1; done_o=1 in cycle k+5; S_IDLE in cycle k+6.
3. Back-to-back into detector: pattern 1011, repeat_i=2, gap_i=0 -> 8 contiguous valid bits 10111011 with no bubble; the detector's detected_o fires twice, 4 cycles apart; busy_o is high for exactly 8 cycles.
4. Gap: pattern 1011, repeat_i=3, gap_i=2 -> busy for 3*4+2*2=16 cycles; valid_o=0 with signal_o=0 for exactly 2 cycles between repeats; a single done_o pulse at the end.
5. Abort and ignored start: repeat_i=5, gap_i=0; pulse start_i again in the 2nd busy cycle -> ignored. Assert abort_i in the 6th busy cycle -> S_IDLE next cycle, valid_o=0, no done_o.
6. Zero repeat and illegal state: start with repeat_i=0 -> done_o pulse one cycle after start, valid_o never asserted. Force state to 0110 -> S_IDLE after the next clock.
